// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and width helpers for the trace recorder
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int unsigned DEF_PC_W    = 32;
    localparam int unsigned DEF_IR_W    = 32;
    localparam int unsigned DEF_CW_W    = 37;
    localparam int unsigned DEF_ENTRY_W = DEF_PC_W + DEF_IR_W + DEF_CW_W;

    function automatic int unsigned entry_width(input int unsigned pc_w,
                                                input int unsigned ir_w,
                                                input int unsigned cw_w);
        return pc_w + ir_w + cw_w;
    endfunction

    function automatic int unsigned idx_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port RAM, registered read, read-old on collision
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 101,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Non-blocking read of mem_q in the same edge as the write yields the old word.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/trace_recorder.sv
// rtl/trace_recorder.sv - circular PC/IR/control-word trace buffer with breakpoint and external trigger
module trace_recorder
    import trace_pkg::*;
#(
    parameter int unsigned PC_W      = DEF_PC_W,
    parameter int unsigned IR_W      = DEF_IR_W,
    parameter int unsigned CW_W      = DEF_CW_W,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4,
    parameter int unsigned NUM_BP    = 2
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  arm,
    input  logic                                  sample_en,
    input  logic [PC_W-1:0]                       pc,
    input  logic [IR_W-1:0]                       ir,
    input  logic [CW_W-1:0]                       control_word,
    input  logic [NUM_BP*PC_W-1:0]                bp_addr,
    input  logic [NUM_BP-1:0]                     bp_en,
    input  logic                                  trig_ext,
    input  logic [idx_width(DEPTH)-1:0]           rd_idx,
    output logic [entry_width(PC_W,IR_W,CW_W)-1:0] rd_data,
    output logic [idx_width(DEPTH):0]             count,
    output logic [idx_width(DEPTH)-1:0]           trig_pos,
    output logic                                  armed,
    output logic                                  done
);

    localparam int unsigned IDX_W   = idx_width(DEPTH);
    localparam int unsigned ENTRY_W = entry_width(PC_W, IR_W, CW_W);

    localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   PT_C     = (IDX_W+1)'(POST_TRIG);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] POST_INI = IDX_W'(POST_TRIG);

    trace_state_e     state_q, state_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] post_q, post_d;
    logic [IDX_W-1:0] trig_pos_q, trig_pos_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W:0]   tp_full;
    logic             armed_q, done_q, rd_zero_q;
    logic             bp_hit, trig, wr_en;
    logic [IDX_W-1:0] rd_addr;
    logic [ENTRY_W-1:0] ram_rdata;

    always_comb begin
        bp_hit = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_en[i] && (pc == bp_addr[i*PC_W +: PC_W])) begin
                bp_hit = 1'b1;
            end
        end
    end

    assign trig  = sample_en & (trig_ext | bp_hit);
    // arm wins over a coincident sample, so that sample is never written.
    assign wr_en = sample_en && !arm && ((state_q == ST_ARMED) || (state_q == ST_POST));

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        post_d     = post_q;
        count_d    = count_q;
        trig_pos_d = trig_pos_q;
        tp_full    = '0;
        if (arm) begin
            state_d    = ST_ARMED;
            wr_ptr_d   = '0;
            post_d     = '0;
            count_d    = '0;
            trig_pos_d = '0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (count_q != DEPTH_C) begin
                count_d = count_q + CNT_ONE;
            end
            tp_full = count_d - CNT_ONE - PT_C;
            case (state_q)
                ST_ARMED: begin
                    if (trig) begin
                        if (POST_TRIG > 0) begin
                            state_d = ST_POST;
                            post_d  = POST_INI;
                        end else begin
                            state_d    = ST_DONE;
                            trig_pos_d = tp_full[IDX_W-1:0];
                        end
                    end
                end
                ST_POST: begin
                    post_d = post_q - PTR_ONE;
                    if (post_q == PTR_ONE) begin
                        state_d    = ST_DONE;
                        trig_pos_d = tp_full[IDX_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            post_q     <= '0;
            count_q    <= '0;
            trig_pos_q <= '0;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            post_q     <= post_d;
            count_q    <= count_d;
            trig_pos_q <= trig_pos_d;
            armed_q    <= (state_d == ST_ARMED) || (state_d == ST_POST);
            done_q     <= (state_d == ST_DONE);
            rd_zero_q  <= ({1'b0, rd_idx} >= count_q);
        end
    end

    // Oldest entry sits count slots behind the write pointer.
    assign rd_addr = wr_ptr_q - count_q[IDX_W-1:0] + rd_idx;

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (IDX_W)
    ) u_ram (
        .clock (clock),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({pc, ir, control_word}),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign rd_data  = rd_zero_q ? '0 : ram_rdata;
    assign count    = count_q;
    assign trig_pos = trig_pos_q;
    assign armed    = armed_q;
    assign done     = done_q;

endmodule

// File: doc/trace_recorder.md
# trace_recorder

Parametrised on-chip instruction trace recorder for the multicycle computer. It samples the PC, IR and control word into a circular buffer on each qualified instruction fetch. It stops a programmable number of samples after a breakpoint or external trigger. The captured history can then be read back by the bench or a debug port, replacing fixed-time `$stop` runs with event-driven capture.

## Interface
Parameters:
- `PC_W`, 32, PC width
- `IR_W`, 32, instruction register width
- `CW_W`, 37, control word width
- `DEPTH`, 16, buffer entries; power of two, ≥2
- `POST_TRIG`, 4, samples stored after the trigger sample; 0 ≤ POST_TRIG < DEPTH
- `NUM_BP`, 2, PC breakpoint comparators, ≥1

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `arm`  in  1  one-cycle pulse: clear and start recording
- `sample_en`  in  1  qualify sample this cycle (driven by iFetch)
- `pc`  in  PC_W  sampled PC
- `ir`  in  IR_W  sampled IR
- `control_word`  in  CW_W  sampled control word
- `bp_addr`  in  NUM_BP*PC_W  breakpoint PCs, comparator i at slice i
- `bp_en`  in  NUM_BP  per-comparator enable
- `trig_ext`  in  1  external trigger, qualified by sample_en
- `rd_idx`  in  log2(DEPTH)  read index, 0 = oldest entry
- `rd_data`  out  PC_W+IR_W+CW_W  {pc, ir, control_word} of entry rd_idx
- `count`  out  log2(DEPTH)+1  valid entries, saturates at DEPTH
- `trig_pos`  out  log2(DEPTH)  oldest-relative index of trigger sample
- `armed`  out  1  state is ARMED or POST
- `done`  out  1  capture complete

## Operation
- States: IDLE, ARMED, POST, DONE.
- IDLE: no writes. `arm` → ARMED with count=0 and write pointer 0.
- ARMED: each cycle with sample_en=1 writes one entry at wr_ptr; wr_ptr increments mod DEPTH; count increments, saturating at DEPTH.
- Trigger = sample_en & (trig_ext | OR over i of (bp_en[i] & pc==bp_addr[i])). It is one event no matter how many sources match.
- On a trigger in ARMED, the trigger sample is written.
  - POST_TRIG>0: go to POST with post counter = POST_TRIG.
  - POST_TRIG=0: go to DONE.
- POST: each sample is written and decrements the post counter. The edge that writes the sample taking it to 0 moves to DONE. Further triggers in POST are ignored.
- DONE: no writes. Buffer and count hold. `arm` → ARMED, clearing count.
- `arm` in ARMED or POST restarts the capture: count=0, wr_ptr=0, state ARMED. If `arm` and sample_en are high together, arm takes priority and that sample is discarded.
- Read mapping: physical = (wr_ptr − count + rd_idx) mod DEPTH.
- rd_idx ≥ count reads as all zeros.
- Reads are valid in every state. In ARMED/POST the data may be overwritten.
- trig_pos = count − 1 − POST_TRIG, registered on entry to DONE. It holds 0 outside DONE.

## Timing
- Reset: state IDLE; count, wr_ptr, post counter, trig_pos, rd_data = 0; armed=0, done=0.
- Reset takes priority over arm and sample_en. Reset mid-POST gives IDLE with count=0.
- Sample write, count update and state transition all occur on the same rising edge that sees sample_en=1.
- armed and done are registered. done is high the cycle after the final post-trigger write.
- rd_data is registered: 1-cycle latency from rd_idx.
- Simultaneous read and write of the same physical entry returns the old data.

## Structure
- Package `trace_pkg`:
  - state enum (IDLE, ARMED, POST, DONE)
  - localparam entry width = PC_W+IR_W+CW_W
  - index width via $clog2
- Sub-module `trace_ram`:
  - simple dual-port RAM, DEPTH × entry width
  - one write port, one registered read port, read-old-on-collision
- The top contains the FSM, pointers, breakpoint comparators and read address arithmetic.

## Test plan
All scenarios use DEPTH=16 and POST_TRIG=4. Samples are sample_en=1 every cycle with pc = 4·n for n = 0, 1, 2, …
- Reset with `arm` and sample_en high → state IDLE, count=0, done=0, rd_data=0 on the following cycle.
- `arm`, bp_addr[0]=0x28, bp_en=01 → trigger at n=10. DONE after pc=0x38 is written. count=15, trig_pos=10. rd_idx=0 gives pc 0; rd_idx=14 gives pc 0x38.
- Wrap: bp_addr[0]=0x80 → last pc written 0x90. count=16, rd_idx=0 gives pc 0x54, trig_pos=11, rd_idx=15 gives pc 0x90.
- trig_ext and bp match on the same sample → a single trigger, exactly 4 post samples. `arm` pulsed while in POST → ARMED with count=0 and no done.
- sample_en toggled 1/0 → count advances only on high cycles. Reset asserted mid-POST → IDLE and count=0 on the next cycle.
- POST_TRIG=0 build with trigger at pc 0x8 → done high the cycle after that write. count=3, trig_pos=2.
